// File: rtl/subword_scheduler.sv
// -----------------------------------------------------------------------------
// subword_scheduler
//
// Shares one multi-cycle dual-rail SubWord unit between two requesters
// (key expansion on port 0, round datapath on port 1). A job is accepted in
// IDLE, then runs one precharge (spacer) cycle, four evaluate cycles stepping
// the SubWord phase counter 0..3, and one capture cycle. The result is
// registered and reported one cycle later. The whole job takes 7 cycles from
// Ack to Res_Valid.
//
// Ports
//   Clk, Reset                    clock; synchronous active-high reset
//   ReqN_Valid, ReqN_Word_T/F     requester N pending flag and dual-rail operand
//   ReqN_Ack                      one-cycle accept pulse for requester N
//   Sw_Multi_Cycle_State          SubWord phase (0..3)
//   Sw_In_T / Sw_In_F             SubWord dual-rail input (all zero = spacer)
//   Sw_Flipflop_Ind               SubWord mode: 0 = precharge, 1 = evaluate
//   Sw_Out_T / Sw_Out_F           SubWord dual-rail output
//   Res_Valid, Res_Id             result strobe and owning requester
//   Res_Word_T / Res_Word_F       registered dual-rail result
//   Rail_Err                      sticky dual-rail check failure flag
// -----------------------------------------------------------------------------
module subword_scheduler #(
  parameter int WORD = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Req0_Valid,
  input  logic [WORD-1:0] Req0_Word_T,
  input  logic [WORD-1:0] Req0_Word_F,
  input  logic            Req1_Valid,
  input  logic [WORD-1:0] Req1_Word_T,
  input  logic [WORD-1:0] Req1_Word_F,
  output logic            Req0_Ack,
  output logic            Req1_Ack,
  output logic [1:0]      Sw_Multi_Cycle_State,
  output logic [WORD-1:0] Sw_In_T,
  output logic [WORD-1:0] Sw_In_F,
  output logic            Sw_Flipflop_Ind,
  input  logic [WORD-1:0] Sw_Out_T,
  input  logic [WORD-1:0] Sw_Out_F,
  output logic            Res_Valid,
  output logic            Res_Id,
  output logic [WORD-1:0] Res_Word_T,
  output logic [WORD-1:0] Res_Word_F,
  output logic            Rail_Err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRECH = 2'd1,
    EVAL  = 2'd2,
    CAPT  = 2'd3
  } state_t;

  // A valid dual-rail word has exactly one rail high on every bit.
  function automatic logic rail_ok(input logic [WORD-1:0] t, input logic [WORD-1:0] f);
    return ((t ^ f) == {WORD{1'b1}});
  endfunction

  state_t          state_r, state_s;
  logic [1:0]      cnt_r, cnt_s;
  logic            ptr_r, ptr_s;
  logic            win_r, win_s;
  logic [WORD-1:0] op_t_r, op_t_s;
  logic [WORD-1:0] op_f_r, op_f_s;
  logic            grant0_s, grant1_s;

  logic            sw_ffi_r, sw_ffi_s;
  logic [1:0]      sw_mcs_r, sw_mcs_s;
  logic [WORD-1:0] sw_t_r, sw_t_s;
  logic [WORD-1:0] sw_f_r, sw_f_s;

  logic            res_valid_r, res_valid_s;
  logic            res_id_r, res_id_s;
  logic [WORD-1:0] res_t_r, res_t_s;
  logic [WORD-1:0] res_f_r, res_f_s;
  logic            rail_err_r, rail_err_s;

  // Next-state, round-robin arbitration and operand capture.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    ptr_s    = ptr_r;
    win_s    = win_r;
    op_t_s   = op_t_r;
    op_f_s   = op_f_r;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (Req0_Valid || Req1_Valid) begin
          // Under contention the requester that did not win last time goes first.
          if (Req0_Valid && Req1_Valid) begin
            win_s = ~ptr_r;
          end else begin
            win_s = Req1_Valid;
          end
          ptr_s    = win_s;
          grant0_s = ~win_s;
          grant1_s = win_s;
          if (win_s) begin
            op_t_s = Req1_Word_T;
            op_f_s = Req1_Word_F;
          end else begin
            op_t_s = Req0_Word_T;
            op_f_s = Req0_Word_F;
          end
          state_s = PRECH;
        end else begin
          state_s = IDLE;
        end
      end
      PRECH: begin
        state_s = EVAL;
        cnt_s   = 2'd0;
      end
      EVAL: begin
        // The counter stays at 3 through CAPT so the phase output holds there.
        if (cnt_r == 2'd3) begin
          state_s = CAPT;
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
      CAPT: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // SubWord drive for the coming cycle plus result capture and rail check.
  always_comb begin
    sw_ffi_s    = 1'b0;
    sw_mcs_s    = 2'd0;
    sw_t_s      = {WORD{1'b0}};
    sw_f_s      = {WORD{1'b0}};
    res_valid_s = 1'b0;
    res_id_s    = res_id_r;
    res_t_s     = res_t_r;
    res_f_s     = res_f_r;
    rail_err_s  = rail_err_r;
    case (state_s)
      EVAL, CAPT: begin
        sw_ffi_s = 1'b1;
        sw_mcs_s = cnt_s;
        sw_t_s   = op_t_s;
        sw_f_s   = op_f_s;
      end
      default: begin
        // IDLE and PRECH present the all-zero spacer so no S-box toggles.
        sw_ffi_s = 1'b0;
      end
    endcase
    if (state_r == CAPT) begin
      res_valid_s = 1'b1;
      res_id_s    = win_r;
      res_t_s     = Sw_Out_T;
      res_f_s     = Sw_Out_F;
      if (!rail_ok(Sw_Out_T, Sw_Out_F)) begin
        rail_err_s = 1'b1;
      end else begin
        rail_err_s = rail_err_r;
      end
    end else begin
      res_valid_s = 1'b0;
    end
  end

  // Acks answer the requester in the same cycle; a Reset cycle never acks.
  always_comb begin
    Req0_Ack = 1'b0;
    Req1_Ack = 1'b0;
    if (!Reset) begin
      Req0_Ack = grant0_s;
      Req1_Ack = grant1_s;
    end else begin
      Req0_Ack = 1'b0;
      Req1_Ack = 1'b0;
    end
  end

  // State, operand, SubWord drive and result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      ptr_r       <= 1'b1;
      win_r       <= 1'b0;
      op_t_r      <= {WORD{1'b0}};
      op_f_r      <= {WORD{1'b0}};
      sw_ffi_r    <= 1'b0;
      sw_mcs_r    <= 2'd0;
      sw_t_r      <= {WORD{1'b0}};
      sw_f_r      <= {WORD{1'b0}};
      res_valid_r <= 1'b0;
      res_id_r    <= 1'b0;
      res_t_r     <= {WORD{1'b0}};
      res_f_r     <= {WORD{1'b0}};
      rail_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ptr_r       <= ptr_s;
      win_r       <= win_s;
      op_t_r      <= op_t_s;
      op_f_r      <= op_f_s;
      sw_ffi_r    <= sw_ffi_s;
      sw_mcs_r    <= sw_mcs_s;
      sw_t_r      <= sw_t_s;
      sw_f_r      <= sw_f_s;
      res_valid_r <= res_valid_s;
      res_id_r    <= res_id_s;
      res_t_r     <= res_t_s;
      res_f_r     <= res_f_s;
      rail_err_r  <= rail_err_s;
    end
  end

  assign Sw_Flipflop_Ind      = sw_ffi_r;
  assign Sw_Multi_Cycle_State = sw_mcs_r;
  assign Sw_In_T              = sw_t_r;
  assign Sw_In_F              = sw_f_r;
  assign Res_Valid            = res_valid_r;
  assign Res_Id               = res_id_r;
  assign Res_Word_T           = res_t_r;
  assign Res_Word_F           = res_f_r;
  assign Rail_Err             = rail_err_r;

endmodule

// File: tb/tb_subword_scheduler.sv
// -----------------------------------------------------------------------------
// tb_subword_scheduler
//
// Drives two requesters and models the SubWord unit (AES S-box per byte,
// F rail = ~T, optional forced rail fault in the last phase). A reference model
// predicts acks and SubWord drive cycle by cycle from the job timeline and
// pushes expected results into a scoreboard; a separate monitor pops and checks
// them when Res_Valid appears.
// -----------------------------------------------------------------------------
module tb_subword_scheduler;
  localparam int WORD = 32;

  logic            Clk;
  logic            Reset;
  logic            Req0_Valid, Req1_Valid;
  logic [WORD-1:0] Req0_Word_T, Req0_Word_F, Req1_Word_T, Req1_Word_F;
  logic            Req0_Ack, Req1_Ack;
  logic [1:0]      Sw_Multi_Cycle_State;
  logic [WORD-1:0] Sw_In_T, Sw_In_F;
  logic            Sw_Flipflop_Ind;
  logic [WORD-1:0] Sw_Out_T, Sw_Out_F;
  logic            Res_Valid, Res_Id;
  logic [WORD-1:0] Res_Word_T, Res_Word_F;
  logic            Rail_Err;

  subword_scheduler #(.WORD(WORD)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(Req0_Valid), .Req0_Word_T(Req0_Word_T), .Req0_Word_F(Req0_Word_F),
    .Req1_Valid(Req1_Valid), .Req1_Word_T(Req1_Word_T), .Req1_Word_F(Req1_Word_F),
    .Req0_Ack(Req0_Ack), .Req1_Ack(Req1_Ack),
    .Sw_Multi_Cycle_State(Sw_Multi_Cycle_State),
    .Sw_In_T(Sw_In_T), .Sw_In_F(Sw_In_F), .Sw_Flipflop_Ind(Sw_Flipflop_Ind),
    .Sw_Out_T(Sw_Out_T), .Sw_Out_F(Sw_Out_F),
    .Res_Valid(Res_Valid), .Res_Id(Res_Id),
    .Res_Word_T(Res_Word_T), .Res_Word_F(Res_Word_F), .Rail_Err(Rail_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit run_chk = 1'b0;
  bit acked0 = 1'b0, acked1 = 1'b0;
  bit flt0 = 1'b0, flt1 = 1'b0;
  bit inject_cur = 1'b0;

  typedef struct {
    bit          id;
    logic [31:0] t;
    logic [31:0] f;
    bit          flt;
    int          due;
  } job_exp_t;

  job_exp_t sb[$];
  logic        exp_id = 1'b0;
  logic [31:0] exp_rt = 32'h0, exp_rf = 32'h0;
  logic        exp_rail = 1'b0;

  // ---------------- S-box reference ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1B;
      else      a = a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base, ex;
    inv = 8'h01; base = x; ex = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (ex[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
    return r;
  endfunction

  // SubWord unit stand-in: spacer while precharging, S-box while evaluating.
  always_comb begin
    Sw_Out_T = 32'h0;
    Sw_Out_F = 32'h0;
    if (Sw_Flipflop_Ind) begin
      if (inject_cur && Sw_Multi_Cycle_State == 2'd3) begin
        Sw_Out_T = 32'h000000FF;
        Sw_Out_F = 32'h000000FF;
      end else begin
        Sw_Out_T = subword(Sw_In_T);
        Sw_Out_F = ~subword(Sw_In_T);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // ---------------- Monitor: scoreboard pop and held-result checks ----------------
  job_exp_t mon_e;
  bit       mon_due;
  initial forever begin
    @(negedge Clk);
    if (run_chk) begin
      mon_due = (sb.size() > 0) && (sb[0].due == cyc);
      chk1("res_valid", Res_Valid, mon_due);
      if (mon_due) begin
        mon_e  = sb.pop_front();
        exp_id = mon_e.id;
        exp_rt = mon_e.t;
        exp_rf = mon_e.f;
        if (mon_e.flt) exp_rail = 1'b1;
      end
      chk1("res_id", Res_Id, exp_id);
      chk("res_word_t", Res_Word_T, exp_rt);
      chk("res_word_f", Res_Word_F, exp_rf);
      chk1("rail_err", Rail_Err, exp_rail);
    end
  end

  // ---------------- Reference model: job timeline, arbitration ----------------
  int          next_free = 0;
  bit          ptr = 1'b1;
  bit          active = 1'b0;
  int          job_start = 0;
  logic [31:0] job_t = 32'h0, job_f = 32'h0;
  int          m_k;
  bit          m_win, m_e0, m_e1, m_fl;
  logic        e_ffi;
  logic [1:0]  e_mcs;
  logic [31:0] e_t, e_f;
  job_exp_t    m_push;

  initial forever begin
    @(negedge Clk);
    #1;
    if (run_chk) begin
      // Offset 1 is the spacer, 2..5 evaluate phases 0..3, 6 holds phase 3.
      m_k = cyc - job_start;
      e_ffi = 1'b0; e_mcs = 2'd0; e_t = 32'h0; e_f = 32'h0;
      if (active && m_k >= 2 && m_k <= 6) begin
        e_ffi = 1'b1;
        e_mcs = (m_k == 6) ? 2'd3 : 2'(m_k - 2);
        e_t   = job_t;
        e_f   = job_f;
      end
      chk1("sw_flipflop_ind", Sw_Flipflop_Ind, e_ffi);
      chk("sw_multi_cycle_state", 32'(Sw_Multi_Cycle_State), 32'(e_mcs));
      chk("sw_in_t", Sw_In_T, e_t);
      chk("sw_in_f", Sw_In_F, e_f);

      m_e0 = 1'b0; m_e1 = 1'b0;
      if (Reset) begin
        sb.delete();
        next_free  = cyc + 1;
        ptr        = 1'b1;
        active     = 1'b0;
        inject_cur = 1'b0;
        exp_id = 1'b0; exp_rt = 32'h0; exp_rf = 32'h0; exp_rail = 1'b0;
      end else if (cyc >= next_free && (Req0_Valid || Req1_Valid)) begin
        m_win     = (Req0_Valid && Req1_Valid) ? ~ptr : Req1_Valid;
        ptr       = m_win;
        m_e0      = ~m_win;
        m_e1      = m_win;
        next_free = cyc + 7;
        active    = 1'b1;
        job_start = cyc;
        job_t     = m_win ? Req1_Word_T : Req0_Word_T;
        job_f     = m_win ? Req1_Word_F : Req0_Word_F;
        m_fl      = m_win ? flt1 : flt0;
        inject_cur = m_fl;
        m_push.id  = m_win;
        m_push.t   = m_fl ? 32'h000000FF : subword(job_t);
        m_push.f   = m_fl ? 32'h000000FF : ~subword(job_t);
        m_push.flt = m_fl;
        m_push.due = cyc + 7;
        sb.push_back(m_push);
      end
      chk1("req0_ack", Req0_Ack, m_e0);
      chk1("req1_ack", Req1_Ack, m_e1);
      if (Req0_Ack === 1'b1) acked0 = 1'b1;
      if (Req1_Ack === 1'b1) acked1 = 1'b1;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int which, input bit flt);
    logic [31:0] w;
    w = $urandom;
    if (which == 0) begin
      Req0_Valid = 1'b1; Req0_Word_T = w; Req0_Word_F = ~w; flt0 = flt;
    end else begin
      Req1_Valid = 1'b1; Req1_Word_T = w; Req1_Word_F = ~w; flt1 = flt;
    end
  endtask

  task automatic wait_any(output int who, output int at);
    int n;
    n = 0; who = -1; at = -1;
    while (!acked0 && !acked1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!acked0 && !acked1) begin
      failures++;
      $display("FAIL ack_timeout at cycle %0d: got no ack expected one within 20 cycles", cyc);
    end else begin
      who = acked0 ? 0 : 1;
      at  = cyc - 1;
      acked0 = 1'b0;
      acked1 = 1'b0;
    end
  endtask

  int who, at, prev_at, rst_at;
  int ord[3];

  initial begin
    Reset = 1'b1;
    Req0_Valid = 1'b1; Req0_Word_T = 32'h12345678; Req0_Word_F = ~32'h12345678;
    Req1_Valid = 1'b1; Req1_Word_T = 32'h9ABCDEF0; Req1_Word_F = ~32'h9ABCDEF0;
    tick();
    run_chk = 1'b1;
    ticks(2);

    // Single request with an all-zero operand.
    Reset = 1'b0;
    Req1_Valid = 1'b0;
    Req0_Valid = 1'b1; Req0_Word_T = 32'h00000000; Req0_Word_F = 32'hFFFFFFFF; flt0 = 1'b0;
    wait_any(who, at);
    chk("single_who", 32'(who), 32'd0);
    Req0_Valid = 1'b0;
    ticks(8);
    chk("single_res_t", Res_Word_T, 32'h63636363);
    chk("single_res_f", Res_Word_F, 32'h9C9C9C9C);
    chk1("single_res_id", Res_Id, 1'b0);
    chk1("single_rail", Rail_Err, 1'b0);

    // Contention after reset: grants alternate starting with requester 0.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    load(0, 1'b0);
    load(1, 1'b0);
    ord[0] = 0; ord[1] = 1; ord[2] = 0;
    prev_at = 0;
    for (int j = 0; j < 3; j++) begin
      wait_any(who, at);
      chk("contend_order", 32'(who), 32'(ord[j]));
      if (j > 0) chk("contend_spacing", 32'(at - prev_at), 32'd7);
      prev_at = at;
      if (who >= 0) load(who, 1'b0);
    end
    Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    ticks(9);

    // Rail fault on one job, then clean jobs: the flag must stick.
    load(0, 1'b1);
    wait_any(who, at);
    Req0_Valid = 1'b0;
    load(1, 1'b0);
    wait_any(who, at);
    load(1, 1'b0);
    wait_any(who, at);
    Req1_Valid = 1'b0;
    ticks(9);
    chk1("rail_sticky", Rail_Err, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    chk1("rail_cleared", Rail_Err, 1'b0);

    // Reset while evaluating phase 2, with requester 1 already waiting.
    load(0, 1'b0);
    wait_any(who, at);
    Req0_Valid = 1'b0;
    ticks(3);
    chk("mid_eval_phase", 32'(Sw_Multi_Cycle_State), 32'd2);
    Reset = 1'b1;
    rst_at = cyc;
    load(1, 1'b0);
    tick();
    Reset = 1'b0;
    wait_any(who, at);
    chk("post_reset_who", 32'(who), 32'd1);
    chk("post_reset_ack_cycle", 32'(at), 32'(rst_at + 1));
    Req1_Valid = 1'b0;
    ticks(9);

    // Requester 1 raises Valid only while requester 0's job evaluates.
    load(0, 1'b0);
    wait_any(who, at);
    Req0_Valid = 1'b0;
    tick();
    load(1, 1'b0);
    ticks(4);
    Req1_Valid = 1'b0;
    ticks(3);
    chk1("outside_idle_no_ack", acked1, 1'b0);
    chk1("outside_idle_res_id", Res_Id, 1'b0);
    acked1 = 1'b0;

    // Randomized traffic with occasional faults and resets.
    for (int n = 0; n < 500; n++) begin
      if (acked0) begin
        acked0 = 1'b0;
        if ($urandom_range(0, 9) < 7) load(0, $urandom_range(0, 7) == 0);
        else Req0_Valid = 1'b0;
      end else if (!Req0_Valid && $urandom_range(0, 9) < 3) begin
        load(0, $urandom_range(0, 7) == 0);
      end
      if (acked1) begin
        acked1 = 1'b0;
        if ($urandom_range(0, 9) < 7) load(1, $urandom_range(0, 7) == 0);
        else Req1_Valid = 1'b0;
      end else if (!Req1_Valid && $urandom_range(0, 9) < 3) begin
        load(1, $urandom_range(0, 7) == 0);
      end
      Reset = ($urandom_range(0, 59) == 0);
      tick();
    end
    Reset = 1'b0;
    Req0_Valid = 1'b0;
    Req1_Valid = 1'b0;
    ticks(12);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subword_scheduler.md
SUBWORD_SCHEDULER -- requirements
Module: subword_scheduler

Interface
REQ-001 Parameter WORD, 32, width of one dual-rail rail (T or F) in bits; a multiple of 8.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Req0_Valid  input  1  key-expansion requester has a word pending.
REQ-005 Req0_Word_T / Req0_Word_F  input  WORD each  requester-0 dual-rail operand.
REQ-006 Req1_Valid  input  1  round-datapath requester has a word pending.
REQ-007 Req1_Word_T / Req1_Word_F  input  WORD each  requester-1 dual-rail operand.
REQ-008 Req0_Ack / Req1_Ack  output  1 each  one-cycle pulse: operand accepted.
REQ-009 Sw_Multi_Cycle_State  output  2  drives the SubWord Multi_Cycle_State input.
REQ-010 Sw_In_T / Sw_In_F  output  WORD each  drive the SubWord In_Word_T / In_Word_F inputs.
REQ-011 Sw_Flipflop_Ind  output  1  drives the SubWord flipflpoindicator input; 0 = precharge, 1 = evaluate.
REQ-012 Sw_Out_T / Sw_Out_F  input  WORD each  SubWord Out_Word_T / Out_Word_F.
REQ-013 Res_Valid  output  1  one-cycle pulse: result registers updated.
REQ-014 Res_Id  output  1  requester that owns the current result (0 or 1).
REQ-015 Res_Word_T / Res_Word_F  output  WORD each  registered dual-rail result.
REQ-016 Rail_Err  output  1  sticky flag: captured result failed the dual-rail check.

Function
REQ-017 The FSM SHALL have the states IDLE, PRECH, EVAL, CAPT.
REQ-018 IDLE, no Valid: remain in IDLE.
REQ-019 IDLE, any Valid: choose a winner, register its operand, pulse its Ack in the same cycle, and go to PRECH.
REQ-020 Arbitration SHALL be round-robin with a 1-bit last-grant pointer (reset 1, so requester 0 wins first).
REQ-021 Arbitration, both Valid: grant the requester not equal to the pointer, then set the pointer to the winner.
REQ-022 Arbitration, single Valid: grant that requester regardless of the pointer, and update the pointer to it.
REQ-023 PRECH lasts exactly 1 cycle: Sw_Flipflop_Ind=0, Sw_In_T=Sw_In_F=0 (spacer), Sw_Multi_Cycle_State=0; then go to EVAL.
REQ-024 EVAL lasts exactly 4 cycles: Sw_Flipflop_Ind=1, Sw_In_T/F = registered operand.
REQ-025 During EVAL, Sw_Multi_Cycle_State SHALL step 0,1,2,3, one value per cycle, from a 2-bit counter.
REQ-026 In the EVAL cycle with state 3, go to CAPT.
REQ-027 CAPT lasts 1 cycle: register Sw_Out_T/F into Res_Word_T/F, pulse Res_Valid, and set Res_Id to the winner.
REQ-028 CAPT keeps Sw_Flipflop_Ind=1 and Sw_In_T/F = operand, holds Sw_Multi_Cycle_State=3, and goes to IDLE.
REQ-029 Dual-rail check at CAPT: if (Sw_Out_T XOR Sw_Out_F) is not all-ones, set Rail_Err; only Reset clears it.
REQ-030 Res_Valid SHALL still pulse, and Res_Word_T/F SHALL still update, when the dual-rail check fails.
REQ-031 Latency SHALL be 7 cycles from the Ack cycle to the Res_Valid cycle.
REQ-032 Accepts are back-to-back: a new grant may occur in the cycle after CAPT, giving one operand per 7 cycles.
REQ-033 Valid SHALL be ignored outside IDLE; no Ack is issued outside IDLE, and the requester holds its operand.
REQ-034 At most one Ack SHALL be high in any cycle.
REQ-035 In IDLE, Sw_In_T/F=0, Sw_Flipflop_Ind=0 and Sw_Multi_Cycle_State=0, so no data toggles the S-boxes.
REQ-036 Res_Word_T/F and Res_Id SHALL hold their values between Res_Valid pulses.

Reset
REQ-037 Reset has priority over every other event and returns the FSM to IDLE from any state; an in-flight job is discarded with no Res_Valid.
REQ-038 Reset values: Acks=0, Res_Valid=0, Res_Id=0, Res_Word_T/F=0, Rail_Err=0, Sw_*=0, pointer=1, EVAL counter=0.
REQ-039 Valid inputs sampled during a Reset cycle SHALL NOT produce an Ack.

Verification
REQ-040 Single request: Req0_Valid=1, T=0x00000000, F=0xFFFFFFFF -> Req0_Ack in cycle 0; 1 cycle PRECH spacer; Sw_Multi_Cycle_State 0,1,2,3; Res_Valid at cycle 7, Res_Id=0, Res_Word_T=0x63636363, F=~T, Rail_Err=0.
REQ-041 Contention: both Valid held for 3 jobs after Reset -> grant order 0,1,0; Acks 7 cycles apart; never both Acks high.
REQ-042 Rail fault: force Sw_Out_T=Sw_Out_F=0x000000FF in CAPT -> Rail_Err=1 and stays 1 through later clean jobs until Reset.
REQ-043 Reset mid-EVAL (state 2): assert Reset 1 cycle -> no Res_Valid, all outputs at reset values next cycle, a new request is acked 1 cycle after Reset deasserts.
REQ-044 Valid outside IDLE: pulse Req1_Valid during EVAL only -> no Req1_Ack, and Res_Id stays on the requester in flight.
